// File: rtl/pc_gen_ras_pkg.sv
// Shared definitions for the fetch-stage PC generator: default vectors and
// the redirect-source encoding used by the next-PC mux.
package pc_gen_ras_pkg;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0080;

  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_ERET,
    SRC_JUMP,
    SRC_BRANCH,
    SRC_JR,
    SRC_SEQ
  } redir_src_t;

endpackage

// File: rtl/pc_gen_ras_if.sv
// Control/hazard-unit <-> PC generator bundle; master is the control side,
// slave is the PC unit.
interface pc_gen_ras_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             exc;
  logic             eret;
  logic             jump;
  logic [25:0]      jump_idx;
  logic             branch;
  logic [WIDTH-1:0] br_off;
  logic             jump_reg;
  logic [WIDTH-1:0] jr_target;
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_4;
  logic [WIDTH-1:0] link_addr;
  logic [WIDTH-1:0] epc;
  logic             epc_bd;
  logic             redir_pend;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output stall, exc, eret, jump, jump_idx, branch, br_off,
           jump_reg, jr_target, ras_push, ras_pop,
    input  pc, pc_plus_4, link_addr, epc, epc_bd, redir_pend,
           ras_empty, ras_full
  );

  modport slave (
    input  stall, exc, eret, jump, jump_idx, branch, br_off,
           jump_reg, jr_target, ras_push, ras_pop,
    output pc, pc_plus_4, link_addr, epc, epc_bd, redir_pend,
           ras_empty, ras_full
  );
endinterface

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: newest entry at top, count saturates at
// DEPTH so the oldest entry is silently overwritten.
module ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_inc;
  logic [PW-1:0]    top_dec;
  logic [CW-1:0]    count;

  assign top_inc  = top + 1'b1;
  assign top_dec  = top - 1'b1;
  assign top_data = entries[top];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top   <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (push && pop) begin
      // call-through-return: top entry is consumed and refilled in one go
      entries[top] <= push_data;
    end else if (push) begin
      entries[top_inc] <= push_data;
      top              <= top_inc;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      top   <= top_dec;
      count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/pc_gen_ras.sv
// Next-PC generator for the MIPS fetch stage: prioritised redirects, stall,
// optional branch-delay slot, EPC capture and a return-address stack.
module pc_gen_ras
  import pc_gen_ras_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(PC_EXC_VEC),
  parameter int unsigned      DELAY_SLOT = 1,
  parameter int unsigned      RAS_DEPTH  = 4
) (
  input logic         clk,
  input logic         rst,
  pc_gen_ras_if.slave bus
);
  logic [WIDTH-1:0] pc, pc_plus_4, link_addr, epc, pend_tgt;
  logic [WIDTH-1:0] jump_tgt, br_tgt, jr_tgt, tgt, ras_top;
  logic             epc_bd, pend, ras_empty, ras_full;
  logic             live, ras_push_eff, ras_pop_eff;
  redir_src_t       src;

  assign pc_plus_4 = pc + WIDTH'(4);
  assign link_addr = (DELAY_SLOT != 0) ? pc + WIDTH'(8) : pc_plus_4;
  assign jump_tgt  = {pc_plus_4[WIDTH-1:28], bus.jump_idx, 2'b00};
  assign br_tgt    = pc_plus_4 + bus.br_off;
  assign jr_tgt    = (bus.ras_pop && !ras_empty) ? ras_top : bus.jr_target;

  // Redirects are not considered while a delay-slot redirect is pending.
  always_comb begin
    src = SRC_SEQ;
    tgt = pc_plus_4;
    if (bus.exc)       src = SRC_EXC;
    else if (bus.eret) src = SRC_ERET;
    else if (!pend) begin
      if (bus.jump)          begin src = SRC_JUMP;   tgt = jump_tgt; end
      else if (bus.branch)   begin src = SRC_BRANCH; tgt = br_tgt;   end
      else if (bus.jump_reg) begin src = SRC_JR;     tgt = jr_tgt;   end
    end
  end

  assign live         = !bus.exc && !bus.eret && !bus.stall;
  assign ras_push_eff = live && bus.ras_push;
  assign ras_pop_eff  = live && (src == SRC_JR) && bus.ras_pop && !ras_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_VEC;
      epc      <= '0;
      epc_bd   <= 1'b0;
      pend     <= 1'b0;
      pend_tgt <= '0;
    end else begin
      case (src)
        SRC_EXC: begin
          epc    <= pend ? pc - WIDTH'(4) : pc;
          epc_bd <= pend;
          pc     <= EXC_VEC;
          pend   <= 1'b0;
        end
        SRC_ERET: begin
          pc   <= epc;
          pend <= 1'b0;
        end
        default: begin
          if (!bus.stall) begin
            if (pend) begin
              pc   <= pend_tgt;
              pend <= 1'b0;
            end else if (src == SRC_SEQ) begin
              pc <= pc_plus_4;
            end else if (DELAY_SLOT != 0) begin
              pend_tgt <= tgt;
              pend     <= 1'b1;
              pc       <= pc_plus_4;
            end else begin
              pc <= tgt;
            end
          end
        end
      endcase
    end
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push_eff),
    .pop       (ras_pop_eff),
    .push_data (link_addr),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign bus.pc         = pc;
  assign bus.pc_plus_4  = pc_plus_4;
  assign bus.link_addr  = link_addr;
  assign bus.epc        = epc;
  assign bus.epc_bd     = epc_bd;
  assign bus.redir_pend = pend;
  assign bus.ras_empty  = ras_empty;
  assign bus.ras_full   = ras_full;
endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras (DELAY_SLOT=1, RAS_DEPTH=4): directed scenarios plus
// random traffic against a queue-based reference model.
module tb_pc_gen_ras;
  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_gen_ras_if #(.WIDTH(32)) bus ();

  pc_gen_ras #(
    .WIDTH      (32),
    .DELAY_SLOT (1),
    .RAS_DEPTH  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] m_pc, m_tgt, m_epc;
  bit          m_pend, m_bd;
  logic [31:0] ras_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle();
    bus.stall = 0; bus.exc = 0; bus.eret = 0; bus.jump = 0; bus.jump_idx = '0;
    bus.branch = 0; bus.br_off = '0; bus.jump_reg = 0; bus.jr_target = '0;
    bus.ras_push = 0; bus.ras_pop = 0;
  endtask

  // Architectural effect of one clock edge given the current inputs.
  task automatic model_edge();
    logic [31:0] tgt, link;
    bit redir, pop_ok;
    link   = m_pc + 32'd8;
    redir  = 0;
    pop_ok = 0;
    tgt    = '0;
    if (bus.exc) begin
      m_epc  = m_pend ? m_pc - 32'd4 : m_pc;
      m_bd   = m_pend;
      m_pc   = 32'h80;
      m_pend = 0;
    end else if (bus.eret) begin
      m_pc   = m_epc;
      m_pend = 0;
    end else if (!bus.stall) begin
      if (!m_pend) begin
        if (bus.jump) begin
          redir = 1;
          tgt   = {m_pc[31:28] + 4'(((m_pc & 32'h0FFF_FFFF) + 4) >> 28), bus.jump_idx, 2'b00};
        end else if (bus.branch) begin
          redir = 1;
          tgt   = m_pc + 32'd4 + bus.br_off;
        end else if (bus.jump_reg) begin
          redir = 1;
          if (bus.ras_pop && ras_q.size() > 0) begin
            tgt    = ras_q[ras_q.size() - 1];
            pop_ok = 1;
          end else tgt = bus.jr_target;
        end
      end
      if (bus.ras_push && pop_ok) ras_q[ras_q.size() - 1] = link;
      else if (bus.ras_push) begin
        ras_q.push_back(link);
        if (ras_q.size() > 4) void'(ras_q.pop_front());
      end else if (pop_ok) void'(ras_q.pop_back());
      if (m_pend) begin
        m_pc   = m_tgt;
        m_pend = 0;
      end else if (redir) begin
        m_tgt  = tgt;
        m_pend = 1;
        m_pc   = m_pc + 32'd4;
      end else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},        bus.pc,         m_pc);
    check({tag, ".pc4"},       bus.pc_plus_4,  m_pc + 32'd4);
    check({tag, ".link"},      bus.link_addr,  m_pc + 32'd8);
    check({tag, ".epc"},       bus.epc,        m_epc);
    check({tag, ".epc_bd"},    32'(bus.epc_bd),     32'(m_bd));
    check({tag, ".pend"},      32'(bus.redir_pend), 32'(m_pend));
    check({tag, ".ras_empty"}, 32'(bus.ras_empty),  32'(ras_q.size() == 0));
    check({tag, ".ras_full"},  32'(bus.ras_full),   32'(ras_q.size() == 4));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1;
    #2;
    m_pc = 32'h0; m_tgt = '0; m_epc = '0; m_pend = 0; m_bd = 0;
    ras_q.delete();
    check_all("rst_on");
    @(posedge clk);
    #1;
    rst = 0;
    check_all("rst_off");
  endtask

  task automatic goto(input logic [31:0] addr);
    idle();
    bus.jump     = 1;
    bus.jump_idx = addr[27:2];
    step("goto");
    idle();
    step("goto_ds");
    check("goto_pc", bus.pc, addr);
  endtask

  logic [31:0] links [5];
  logic [31:0] held_pc;
  logic [31:0] r;

  initial begin
    idle();
    do_reset();

    // branch with delay slot
    goto(32'h100);
    bus.branch = 1; bus.br_off = 32'h40;
    step("br");
    check("br_ds_pc", bus.pc, 32'h104);
    check("br_ds_pend", 32'(bus.redir_pend), 32'd1);
    idle();
    step("br_tgt");
    check("br_tgt_pc", bus.pc, 32'h144);
    check("br_tgt_pend", 32'(bus.redir_pend), 32'd0);

    // exception inside a delay slot, then return
    goto(32'h100);
    bus.branch = 1; bus.br_off = 32'h40;
    step("exbr");
    idle();
    bus.exc = 1;
    step("exc");
    check("exc_pc", bus.pc, 32'h80);
    check("exc_epc", bus.epc, 32'h100);
    check("exc_bd", 32'(bus.epc_bd), 32'd1);
    idle();
    bus.eret = 1;
    step("eret");
    check("eret_pc", bus.pc, 32'h100);
    idle();

    // JAL then JR through the RAS
    goto(32'h200);
    check("jal_link", bus.link_addr, 32'h208);
    bus.jump = 1; bus.jump_idx = 26'(32'h300 >> 2); bus.ras_push = 1;
    step("jal");
    idle();
    step("jal_ds");
    bus.jump_reg = 1; bus.ras_pop = 1; bus.jr_target = 32'h0;
    step("jr");
    idle();
    step("jr_ds");
    check("jr_pc", bus.pc, 32'h208);
    check("jr_empty", 32'(bus.ras_empty), 32'd1);

    // overfill the stack, then drain it
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.ras_push = 1;
      links[i] = bus.link_addr;
      step("push");
      if (i == 3) check("push4_full", 32'(bus.ras_full), 32'd1);
    end
    for (int j = 0; j < 5; j++) begin
      idle();
      bus.jump_reg = 1; bus.ras_pop = 1; bus.jr_target = 32'h0000_4000;
      step("pop");
      idle();
      step("pop_ds");
      check("pop_pc", bus.pc, (j < 4) ? links[4 - j] : 32'h0000_4000);
    end

    // stall freezes everything, but an exception still wins
    idle();
    held_pc = bus.pc;
    bus.stall = 1; bus.branch = 1; bus.br_off = 32'h20; bus.ras_push = 1;
    repeat (3) step("stall");
    check("stall_pc", bus.pc, held_pc);
    check("stall_pend", 32'(bus.redir_pend), 32'd0);
    bus.exc = 1;
    step("stall_exc");
    check("stall_exc_pc", bus.pc, 32'h80);
    idle();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      idle();
      r = $urandom;
      bus.exc       = ($urandom_range(0, 15) == 0);
      bus.eret      = ($urandom_range(0, 15) == 0);
      bus.stall     = ($urandom_range(0, 4) == 0);
      bus.jump      = ($urandom_range(0, 5) == 0);
      bus.jump_idx  = 26'($urandom);
      bus.branch    = ($urandom_range(0, 5) == 0);
      bus.br_off    = {{20{r[9]}}, r[9:0], 2'b00};
      bus.jump_reg  = ($urandom_range(0, 5) == 0);
      bus.jr_target = {$urandom, 2'b00} >> 2 << 2;
      bus.ras_push  = ($urandom_range(0, 3) == 0);
      bus.ras_pop   = ($urandom_range(0, 1) == 0);
      step("rnd");
    end

    // reset in the middle of a run
    idle();
    do_reset();
    check("mid_rst_pc0", bus.pc, 32'h0);
    step("free1");
    check("mid_rst_pc1", bus.pc, 32'h4);
    step("free2");
    check("mid_rst_pc2", bus.pc, 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
